// File: rtl/character_jump_pkg.sv
// Shared types and VGA bus field positions for the SkyHop character block.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

package character_jump_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_JUMP = 1'b1
  } state_t;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Bus layout: {vcount[10:0], vsync, vblnk, hcount[10:0], hsync, hblnk, rgb[11:0]}
  localparam int RGB_LSB = 0;
  localparam int HC_LSB  = 14;
  localparam int VC_LSB  = 27;

endpackage

// File: rtl/character_jump_draw_rect.sv
// Overlays a solid rectangle at (xpos, ypos) onto the VGA bus; one registered stage.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module draw_rect
  import character_jump_pkg::*;
#(
  parameter logic [11:0] COLOR  = 12'hFFF,
  parameter int          WIDTH  = 60,
  parameter int          HEIGHT = 60
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [9:0]                xpos,
  input  logic [9:0]                ypos,
  input  logic [`VGA_BUS_SIZE-1:0]  vga_bus_in,
  output logic [`VGA_BUS_SIZE-1:0]  vga_bus_out
);

  logic [10:0] hc;
  logic [10:0] vc;
  logic [11:0] x0;
  logic [11:0] y0;
  logic        in_x;
  logic        in_y;

  assign hc   = vga_bus_in[HC_LSB +: 11];
  assign vc   = vga_bus_in[VC_LSB +: 11];
  assign x0   = {2'b00, xpos};
  assign y0   = {2'b00, ypos};
  assign in_x = ({1'b0, hc} >= x0) && ({1'b0, hc} < x0 + 12'(WIDTH));
  assign in_y = ({1'b0, vc} >= y0) && ({1'b0, vc} < y0 + 12'(HEIGHT));

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_bus_out <= '0;
    end else begin
      vga_bus_out <= vga_bus_in;
      if (en && in_x && in_y) vga_bus_out[RGB_LSB +: 12] <= COLOR;
    end
  end

endmodule

// File: rtl/character_jump.sv
// Ballistic jump controller: per-tick horizontal step with clamping, decrementing vertical
// velocity, one-deep buffered jump request, and the character drawn via draw_rect.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module character_jump
  import character_jump_pkg::*;
#(
  parameter int          GAME_WIDTH  = 800,
  parameter int          CHAR_WIDTH  = 60,
  parameter int          CHAR_HEIGHT = 60,
  parameter int          GROUND_Y    = 500,
  parameter int          JUMP_V0     = 20,
  parameter int          JUMP_DX     = 2,
  parameter logic [11:0] CHAR_COLOR  = 12'hFF0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      module_en,
  input  logic                      jump_left,
  input  logic                      jump_right,
  input  logic                      one_ms_tick,
  output logic                      landed,
  output logic                      busy,
  output logic [9:0]                xpos,
  output logic [9:0]                ypos,
  input  logic [`VGA_BUS_SIZE-1:0]  vga_bus_in,
  output logic [`VGA_BUS_SIZE-1:0]  vga_bus_out
);

  localparam logic [10:0]       X_MAX    = 11'(GAME_WIDTH - CHAR_WIDTH);
  localparam logic [9:0]        X_RESET  = 10'((GAME_WIDTH - CHAR_WIDTH) / 2);
  localparam logic [9:0]        Y_GROUND = 10'(GROUND_Y);
  localparam logic signed [7:0] VY_START = 8'(JUMP_V0);
  localparam logic signed [7:0] VY_LAND  = -VY_START;

  state_t            state, state_nxt;
  logic              dir, dir_nxt;
  logic signed [7:0] vy, vy_nxt;
  logic [9:0]        x, x_nxt, y, y_nxt;
  logic              buf_vld, buf_vld_nxt, buf_dir, buf_dir_nxt;
  logic              landed_nxt;
  logic              go;

  logic [10:0]        x_dec, x_inc;
  logic signed [10:0] y_sum;

  assign x_dec = {1'b0, x} - 11'(JUMP_DX);
  assign x_inc = {1'b0, x} + 11'(JUMP_DX);
  // vy is positive going up, so the screen y shrinks by vy each tick
  assign y_sum = $signed({1'b0, y}) - $signed({{3{vy[7]}}, vy});

  always_comb begin
    state_nxt   = state;
    dir_nxt     = dir;
    vy_nxt      = vy;
    x_nxt       = x;
    y_nxt       = y;
    buf_vld_nxt = buf_vld;
    buf_dir_nxt = buf_dir;
    landed_nxt  = 1'b0;
    go          = 1'b0;
    case (state)
      S_IDLE: begin
        if (module_en) begin
          if (buf_vld) begin
            go      = 1'b1;
            dir_nxt = buf_dir;
          end else if (jump_left || jump_right) begin
            go      = 1'b1;
            dir_nxt = jump_left ? DIR_LEFT : DIR_RIGHT;
          end
        end
        if (go) begin
          vy_nxt      = VY_START;
          buf_vld_nxt = 1'b0;
          state_nxt   = S_JUMP;
        end
      end
      S_JUMP: begin
        if (!buf_vld && (jump_left || jump_right)) begin
          buf_vld_nxt = 1'b1;
          buf_dir_nxt = jump_left ? DIR_LEFT : DIR_RIGHT;
        end
        if (one_ms_tick) begin
          if (dir == DIR_LEFT) x_nxt = x_dec[10] ? 10'd0 : x_dec[9:0];
          else                 x_nxt = (x_inc > X_MAX) ? X_MAX[9:0] : x_inc[9:0];
          y_nxt = y_sum[10] ? 10'd0 : y_sum[9:0];
          if (vy == VY_LAND) begin
            y_nxt      = Y_GROUND;
            landed_nxt = 1'b1;
            state_nxt  = S_IDLE;
          end else begin
            vy_nxt = vy - 8'sd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      dir     <= DIR_RIGHT;
      vy      <= '0;
      x       <= X_RESET;
      y       <= Y_GROUND;
      buf_vld <= 1'b0;
      buf_dir <= DIR_RIGHT;
      landed  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      dir     <= dir_nxt;
      vy      <= vy_nxt;
      x       <= x_nxt;
      y       <= y_nxt;
      buf_vld <= buf_vld_nxt;
      buf_dir <= buf_dir_nxt;
      landed  <= landed_nxt;
      busy    <= (state_nxt == S_JUMP);
    end
  end

  assign xpos = x;
  assign ypos = y;

  draw_rect #(
    .COLOR  (CHAR_COLOR),
    .WIDTH  (CHAR_WIDTH),
    .HEIGHT (CHAR_HEIGHT)
  ) u_draw_rect (
    .clk         (clk),
    .rst         (rst),
    .en          (module_en),
    .xpos        (x),
    .ypos        (y),
    .vga_bus_in  (vga_bus_in),
    .vga_bus_out (vga_bus_out)
  );

endmodule

// File: tb/tb_character_jump.sv
// Directed bench for character_jump with JUMP_V0=4, JUMP_DX=2.
`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

module tb_character_jump;
  import character_jump_pkg::*;

  logic clk = 1'b0;
  logic rst, module_en, jump_left, jump_right, one_ms_tick;
  logic landed, busy;
  logic [9:0] xpos, ypos;
  logic [`VGA_BUS_SIZE-1:0] vga_bus_in, vga_bus_out;

  int errors = 0;
  int checks = 0;
  int xm;
  int ey[9] = '{496, 493, 491, 490, 490, 491, 493, 496, 500};

  typedef struct {
    logic jl, jr, t;
    logic busy, landed;
    logic [9:0] x, y;
  } vec_t;
  vec_t vecs[$];

  character_jump #(
    .GAME_WIDTH(800), .CHAR_WIDTH(60), .CHAR_HEIGHT(60), .GROUND_Y(500),
    .JUMP_V0(4), .JUMP_DX(2), .CHAR_COLOR(12'hFF0)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en),
    .jump_left(jump_left), .jump_right(jump_right), .one_ms_tick(one_ms_tick),
    .landed(landed), .busy(busy), .xpos(xpos), .ypos(ypos),
    .vga_bus_in(vga_bus_in), .vga_bus_out(vga_bus_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic l, input logic r, input logic t);
    @(negedge clk);
    jump_left   = l;
    jump_right  = r;
    one_ms_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic l, r, t, b, ld, input int x, y);
    vecs.push_back('{l, r, t, b, ld, 10'(x), 10'(y)});
  endtask

  // Nine ticks of one jump; reqs[2i+1:2i] = {left,right} driven on the idle cycle after tick i.
  task automatic jump_arc(input string tag, input int dx, input logic [17:0] reqs);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      xm += dx;
      if (xm < 0) xm = 0;
      if (xm > 740) xm = 740;
      chk({tag, "_y"}, 32'(ypos), 32'(ey[i]));
      chk({tag, "_x"}, 32'(xpos), 32'(xm));
      if (i < 8) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_landed"}, 32'(landed), 32'd0);
        cyc(reqs[2*i+1], reqs[2*i], 1'b0);
      end else begin
        chk({tag, "_land_pulse"}, 32'(landed), 32'd1);
        chk({tag, "_busy_drop"}, 32'(busy), 32'd0);
      end
    end
  endtask

  function automatic logic [`VGA_BUS_SIZE-1:0] mk_bus(input int hc, input int vc, input logic [11:0] rgb);
    logic [`VGA_BUS_SIZE-1:0] b;
    b = '0;
    b[HC_LSB +: 11] = 11'(hc);
    b[VC_LSB +: 11] = 11'(vc);
    b[RGB_LSB +: 12] = rgb;
    return b;
  endfunction

  task automatic draw_chk(input string name, input logic en, input int hc, input int vc, input logic [11:0] exp_rgb);
    @(negedge clk);
    module_en  = en;
    vga_bus_in = mk_bus(hc, vc, 12'h123);
    @(posedge clk);
    #1;
    chk(name, 32'(vga_bus_out[RGB_LSB +: 12]), 32'(exp_rgb));
  endtask

  initial begin
    rst = 1'b1; module_en = 1'b1; jump_left = 1'b0; jump_right = 1'b0;
    one_ms_tick = 1'b0; vga_bus_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_x", 32'(xpos), 32'd370);
    chk("rst_y", 32'(ypos), 32'd500);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_landed", 32'(landed), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Idle ticks, then one right jump cycle by cycle.
    add(0, 0, 1, 0, 0, 370, 500);
    add(0, 0, 1, 0, 0, 370, 500);
    add(0, 1, 0, 1, 0, 370, 500);
    add(0, 0, 1, 1, 0, 372, 496);
    add(0, 0, 0, 1, 0, 372, 496);
    add(0, 0, 1, 1, 0, 374, 493);
    add(0, 0, 1, 1, 0, 376, 491);
    add(0, 0, 1, 1, 0, 378, 490);
    add(0, 0, 1, 1, 0, 380, 490);
    add(0, 0, 1, 1, 0, 382, 491);
    add(0, 0, 1, 1, 0, 384, 493);
    add(0, 0, 1, 1, 0, 386, 496);
    add(0, 0, 1, 0, 1, 388, 500);
    add(0, 0, 0, 0, 0, 388, 500);
    add(0, 0, 1, 0, 0, 388, 500);
    foreach (vecs[i]) begin
      cyc(vecs[i].jl, vecs[i].jr, vecs[i].t);
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_landed", i), 32'(landed), 32'(vecs[i].landed));
      chk($sformatf("vec%0d_x", i), 32'(xpos), 32'(vecs[i].x));
      chk($sformatf("vec%0d_y", i), 32'(ypos), 32'(vecs[i].y));
    end
    xm = 388;

    // Right jump with a buffered left request and a later request that must be dropped.
    cyc(1'b0, 1'b1, 1'b0);
    chk("buf_launch_busy", 32'(busy), 32'd1);
    jump_arc("buf1", 2, 18'h00108);
    cyc(1'b0, 1'b0, 1'b0);
    chk("buf_relaunch_busy", 32'(busy), 32'd1);
    chk("buf_landed_once", 32'(landed), 32'd0);
    jump_arc("buf2", -2, 18'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("buf_drop_busy", 32'(busy), 32'd0);
    chk("buf_drop_landed", 32'(landed), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("buf_drop_busy2", 32'(busy), 32'd0);

    // Both directions in one cycle: left wins.
    cyc(1'b1, 1'b1, 1'b0);
    chk("both_busy", 32'(busy), 32'd1);
    jump_arc("both", -2, 18'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("both_idle", 32'(busy), 32'd0);

    // Disabled: requests ignored.
    module_en = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("dis_busy", 32'(busy), 32'd0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("dis_busy2", 32'(busy), 32'd0);
    chk("dis_x", 32'(xpos), 32'(xm));
    module_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    chk("dis_no_late_launch", 32'(busy), 32'd0);

    // Reset mid-jump with the buffer full.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_x", 32'(xpos), 32'd370);
    chk("midrst_y", 32'(ypos), 32'd500);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_landed", 32'(landed), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("midrst_buf_empty", 32'(busy), 32'd0);
    xm = 370;

    // Character overlay at (370,500), 60x60.
    draw_chk("draw_inside", 1'b1, 375, 510, 12'hFF0);
    draw_chk("draw_left_out", 1'b1, 300, 510, 12'h123);
    draw_chk("draw_last_px", 1'b1, 429, 559, 12'hFF0);
    draw_chk("draw_right_edge", 1'b1, 430, 510, 12'h123);
    draw_chk("draw_below", 1'b1, 375, 560, 12'h123);
    draw_chk("draw_disabled", 1'b0, 375, 510, 12'h123);
    chk("draw_hcount_pass", 32'(vga_bus_out[HC_LSB +: 11]), 32'd375);
    module_en = 1'b1;

    // Repeated left jumps until x saturates at 0.
    for (int j = 0; j < 21; j++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("sat_launch", 32'(busy), 32'd1);
      jump_arc($sformatf("sat%0d", j), -2, 18'h0);
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("sat_final_x", 32'(xpos), 32'd0);
    chk("sat_final_y", 32'(ypos), 32'd500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/character_jump.md
Name: character_jump

Overview:
Parametrised player-character motion controller for the SkyHop game screen.
- Replaces the fixed-height, constant-speed sideways hop with a ballistic arc: horizontal step per tick, vertical velocity decremented each tick.
- Adds screen-edge clamping, a one-deep buffered jump request, and exported position/status.
- Sits between the input/game-control logic and the VGA pipeline; draws the character through the existing draw_rect block.

Parameters:
GAME_WIDTH, 800, screen width in pixels
CHAR_WIDTH, 60, character width in pixels
CHAR_HEIGHT, 60, character height in pixels
GROUND_Y, 500, resting top-left y of character
JUMP_V0, 20, initial upward velocity in px/tick; jump lasts 2*JUMP_V0+1 ticks; must be ≤127 and GROUND_Y ≥ JUMP_V0*(JUMP_V0+1)/2
JUMP_DX, 2, horizontal pixels per tick
CHAR_COLOR, 12'hFF0, fill colour passed to draw_rect

Ports:
clk  in  1  pixel/system clock
rst  in  1  synchronous reset, active-high
module_en  in  1  enables jump acceptance and drawing
jump_left  in  1  level request, jump left
jump_right  in  1  level request, jump right
one_ms_tick  in  1  single-cycle motion strobe
landed  out  1  one-cycle pulse at jump end
busy  out  1  high while in S_JUMP
xpos  out  10  current character x
ypos  out  10  current character y
vga_bus_in  in  `VGA_BUS_SIZE  upstream VGA bus
vga_bus_out  out  `VGA_BUS_SIZE  bus with character overlaid

Behaviour:
- Reset state: xpos=(GAME_WIDTH-CHAR_WIDTH)/2 (370), ypos=GROUND_Y, vy=0, dir=0, state S_IDLE, landed=0, busy=0, buffer empty.
  - A reset mid-jump aborts the jump and returns to these values in 1 cycle.
- States: S_IDLE, S_JUMP.
- S_IDLE, module_en=1:
  - Request source is a valid buffer, else the jump_left/jump_right inputs.
  - Left has priority when both are asserted.
  - On a request: latch dir, vy=JUMP_V0, clear buffer, go to S_JUMP next cycle.
  - With module_en=0, requests are ignored and the buffer holds its value.
- S_JUMP, on one_ms_tick only:
  - x_nxt = x ± JUMP_DX, clamped to [0, GAME_WIDTH-CHAR_WIDTH]. Vertical motion continues while x is clamped.
  - y_nxt = y − vy, computed as 11-bit signed, then clamped to ≥0.
  - If vy == −JUMP_V0 on that tick: force y=GROUND_Y, set landed_nxt=1, go to S_IDLE.
  - Otherwise vy = vy − 1.
  - vy is an 8-bit signed value.
- No motion on cycles without one_ms_tick.
- Buffer (one-deep, 1 valid + 1 dir bit):
  - During S_JUMP, the first jump_left/jump_right assertion is captured (left priority).
  - Later requests are dropped until the buffer is consumed.
- landed:
  - Registered; high exactly 1 cycle, the cycle after the final tick.
  - A buffered request launches in that same cycle (state=S_IDLE), so busy re-asserts 1 cycle later.
- busy = (state==S_JUMP), registered.
- Drawing:
  - draw_rect receives xpos/ypos/module_en.
  - Bus latency is set by draw_rect (unchanged); the motion FSM adds no bus latency.
- Net vertical displacement per jump is 0; ypos == GROUND_Y whenever in S_IDLE.

Decomposition:
- Shared macros.vh provides `VGA_BUS_SIZE.
- Package-level constants: state encoding (S_IDLE=1'b0, S_JUMP=1'b1), DIR_LEFT=1'b1/DIR_RIGHT=1'b0.
- Single sub-module: the existing draw_rect, instantiated with CHAR_COLOR/CHAR_WIDTH/CHAR_HEIGHT.
- Motion FSM and buffer stay in character_jump.

Test Plan:
- Reset release:
  - xpos=370, ypos=500, busy=0, landed=0.
  - Ticks with no request → no change.
- JUMP_V0=4, JUMP_DX=2, pulse jump_right:
  - ypos over 9 ticks = 496,493,491,490,490,491,493,496,500.
  - xpos ends at 388.
  - landed pulses once 1 cycle after the 9th tick; busy drops the same cycle.
- Start xpos at 4 via repeated left jumps (JUMP_DX=2):
  - xpos saturates at 0 and never wraps to 1022.
  - ypos arc is unaffected.
- Assert jump_right, then mid-jump assert jump_left for 1 cycle:
  - After landed, a second jump starts with dir=left.
  - A further mid-jump request is dropped.
- jump_left and jump_right asserted in the same cycle → left jump only.
- module_en=0 with a request → stays S_IDLE.
- rst mid-jump → next cycle reset values; buffer empty.
